// File: rtl/sort4_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sort4_sequencer_if : start/operand/result bundle for the 4-element sorter
// Rev 1.0
// ---------------------------------------------------------------------------
interface sort4_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rc;
  logic [WIDTH-1:0] rd;
  logic [2:0]       swaps;

  modport master (
    output start, a, b, c, d,
    input  busy, done, ra, rb, rc, rd, swaps
  );

  modport slave (
    input  start, a, b, c, d,
    output busy, done, ra, rb, rc, rd, swaps
  );
endinterface
`default_nettype wire

// File: rtl/sort4_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sort4_sequencer : 5-step sorting network, one compare-exchange per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module sort4_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sort4_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       swaps_q, swaps_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] v_q [4];
  logic [WIDTH-1:0] v_d [4];
  logic [WIDTH-1:0] r_q [4];
  logic [WIDTH-1:0] r_d [4];

  logic [1:0]       idx_lo, idx_hi;
  logic [WIDTH-1:0] cx_x, cx_y;
  logic             cx_swap;

  // Network order: (0,2) (1,3) (0,1) (2,3) (1,2)
  always_comb begin
    idx_lo = 2'd1;
    idx_hi = 2'd2;
    case (step_q)
      3'd0: begin idx_lo = 2'd0; idx_hi = 2'd2; end
      3'd1: begin idx_lo = 2'd1; idx_hi = 2'd3; end
      3'd2: begin idx_lo = 2'd0; idx_hi = 2'd1; end
      3'd3: begin idx_lo = 2'd2; idx_hi = 2'd3; end
      default: begin idx_lo = 2'd1; idx_hi = 2'd2; end
    endcase
    cx_x    = v_q[idx_lo];
    cx_y    = v_q[idx_hi];
    cx_swap = (cx_x > cx_y);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    swaps_d = swaps_q;
    v_d     = v_q;
    r_d     = r_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          v_d[0]  = bus.a;
          v_d[1]  = bus.b;
          v_d[2]  = bus.c;
          v_d[3]  = bus.d;
          cnt_d   = 3'd0;
          step_d  = 3'd0;
          state_d = SORT;
          busy_d  = 1'b1;
        end
      end
      SORT: begin
        if (cx_swap) begin
          v_d[idx_lo] = cx_y;
          v_d[idx_hi] = cx_x;
          cnt_d       = cnt_q + 3'd1;
        end
        // Final step publishes the post-exchange values and count together.
        if (step_q == 3'd4) begin
          r_d     = v_d;
          swaps_d = cnt_d;
          step_d  = 3'd0;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          step_d  = step_q + 3'd1;
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      cnt_q   <= 3'd0;
      swaps_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      v_q     <= '{default: '0};
      r_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      swaps_q <= swaps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      v_q     <= v_d;
      r_q     <= r_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ra    = r_q[0];
  assign bus.rb    = r_q[1];
  assign bus.rc    = r_q[2];
  assign bus.rd    = r_q[3];
  assign bus.swaps = swaps_q;

endmodule
`default_nettype wire
